vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Sequences the pixel-colour generator stage. Produces the raster position (hcount, vcount), the `bright` qualifier, and the active-low hsync/vsync for a 640x480@60 display.
- Derives a pixel-rate enable from the system clock; all raster state advances only on that enable.
- Bitgen blocks consume `bright`/`hcount`/`vcount` directly. The VGA pins take hsync/vsync.
- `frame_start` and `frame_count` let upstream logic schedule per-frame colour changes.

Parameters:
- CLK_DIV, 2: system clocks per pixel; range 1..16 (50 MHz -> 25 MHz).
- H_VISIBLE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- pix_en, output, 1: one-clk pulse every CLK_DIV clocks; marks a pixel advance.
- hcount, output, 10: horizontal position, 0..H_TOTAL-1.
- vcount, output, 10: vertical position, 0..V_TOTAL-1.
- hsync, output, 1: active-low horizontal sync.
- vsync, output, 1: active-low vertical sync.
- bright, output, 1: high while (hcount, vcount) is in the visible area.
- line_start, output, 1: one-clk pulse when hcount becomes 0.
- frame_start, output, 1: one-clk pulse when (hcount, vcount) becomes (0, 0).
- frame_count, output, 16: frames begun since reset; wraps.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both totals must be ≤1024.
- Divider:
  - div counter runs 0..CLK_DIV-1, incrementing every clk.
  - pix_en is registered and high in the cycle after div == CLK_DIV-1.
  - CLK_DIV=1: pix_en is constantly 1 after reset.
- Raster counters advance on pix_en:
  - hcount wraps H_TOTAL-1 -> 0.
  - vcount increments only when hcount wraps, and wraps V_TOTAL-1 -> 0.
- Reset values:
  - hcount = H_TOTAL-1 (799), vcount = V_TOTAL-1 (524).
  - div = 0, pix_en = 0, hsync = 1, vsync = 1, bright = 0.
  - line_start = 0, frame_start = 0, frame_count = 0.
  - The reset state is the last pixel of a frame, so the first pix_en after reset lands on (0, 0) with no skipped pixel.
- Decode: hsync, vsync and bright are registered and updated in the same clk as the counters. Outputs are always mutually consistent with hcount/vcount, with zero relative latency.
  - bright = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
  - hsync = 0 iff H_VISIBLE+H_FP ≤ hcount < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_VISIBLE+V_FP ≤ vcount < V_VISIBLE+V_FP+V_SYNC (490..491).
  - vsync is evaluated on vcount only, so it changes with the line wrap.
- Pulses:
  - line_start is high for exactly one clk, the cycle in which hcount first shows 0.
  - frame_start is the same, for the cycle in which (hcount, vcount) first shows (0, 0). line_start is also high in that cycle.
  - frame_count increments in the same cycle frame_start rises. After reset, the first frame reads 1 during frame 0. frame_count wraps 0xFFFF -> 0.
- Between pix_en pulses, every output except pix_en is held.
- Reset mid-frame: all state returns to the reset values on the next edge. The next pix_en restarts at (0, 0) with frame_count = 1. No partial sync pulse is stretched: a low hsync/vsync goes high at reset.
- Reset has priority over a simultaneous pix_en.
- Simultaneous line wrap and frame wrap (799, 524) -> (0, 0): both pulses assert and vcount wraps in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (640/16/96/48, 480/10/2/33);
  - derived H_TOTAL/V_TOTAL functions;
  - a localparam for counter width (10).
- One natural sub-module: vga_pix_div (divider plus pix_en register, parameter CLK_DIV). The raster counters and decode stay in vga_timing_ctrl.

Test Plan:
- Reset check: assert reset 3 clks -> hcount=799, vcount=524, hsync=1, vsync=1, bright=0, all pulses 0, frame_count=0. Release with CLK_DIV=2 -> pix_en first high on the 2nd clk; hcount=0, vcount=0, bright=1, line_start=frame_start=1, frame_count=1.
- Horizontal timing: run one line -> bright high for 640 pix_en, hsync low for exactly 96 pix_en starting at hcount=656, hcount wraps 799 -> 0 with vcount+1, one line_start per 800 pix_en (1600 clks).
- Vertical timing: run one full frame -> vsync low exactly for vcount 490..491 (1600 pix_en), bright never high for vcount ≥ 480, frame_start once per 420000 pix_en.
- Reset mid-operation: assert reset at vcount=490, hcount=700 (hsync and vsync both low) -> both go high on the next edge. After release, counting resumes at (0, 0) with frame_count=1.
- CLK_DIV=1 build: pix_en=1 every cycle after reset, and the line period is 800 clks. frame_count forced near wrap: run frames from a 0xFFFE preload (via long sim or a force) -> 0xFFFF then 0x0000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing controller.
//   - default 640x480@60 horizontal/vertical timing (in pixels / lines)
//   - raster counter width and frame counter width
//   - helpers deriving the line and frame totals from the four segments
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W       = 10;
    localparam int FRAME_CNT_W = 16;

    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Pixels per line; must stay <= 2**CNT_W.
    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Lines per frame; must stay <= 2**CNT_W.
    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// ---------------------------------------------------------------------------
// vga_pix_div
// Divides the system clock down to the pixel rate.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   tick_o    high while the divider sits on its last count; the raster
//             registers in the parent load on this so that they change in
//             the same clock as pix_en_o rises
//   pix_en_o  registered one-clock pixel-advance pulse every CLK_DIV clocks
// ---------------------------------------------------------------------------
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o,
    output logic pix_en_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pix_en_q;

    // With CLK_DIV = 1 the counter is stuck at 0 == DIV_LAST, so tick_o
    // stays high and pix_en_o is constantly 1 once out of reset.
    assign tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick_o ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= tick_o;
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// Raster timing for the pixel-colour generator and the VGA sync pins.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   pix_en       one-clock pulse every CLK_DIV clocks (pixel advance)
//   hcount       horizontal position, 0..H_TOTAL-1
//   vcount       vertical position, 0..V_TOTAL-1
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   bright       high inside the visible area
//   line_start   one-clock pulse when hcount becomes 0
//   frame_start  one-clock pulse when (hcount, vcount) becomes (0, 0)
//   frame_count  frames begun since reset, wrapping
// All outputs are registers. Decode is computed from the next-state counter
// values so hsync/vsync/bright always match hcount/vcount in the same clock.
// ---------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   pix_en,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   bright,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

    logic tick;

    cnt_t       hcount_q,      hcount_d;
    cnt_t       vcount_q,      vcount_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       bright_q,      bright_d;
    logic       line_start_q,  line_start_d;
    logic       frame_start_q, frame_start_d;
    frame_cnt_t frame_count_q, frame_count_d;
    logic       h_wrap;
    logic       v_wrap;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk_i    (clk),
        .reset_i  (reset),
        .tick_o   (tick),
        .pix_en_o (pix_en)
    );

    always_comb begin
        h_wrap = (hcount_q == H_LAST);
        v_wrap = (vcount_q == V_LAST);

        hcount_d = h_wrap ? '0 : hcount_q + cnt_t'(1);

        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + cnt_t'(1);
        end

        bright_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        hsync_d  = !((hcount_d >= HS_START) && (hcount_d < HS_END));
        vsync_d  = !((vcount_d >= VS_START) && (vcount_d < VS_END));

        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
        frame_count_d = frame_start_d ? frame_count_q + frame_cnt_t'(1) : frame_count_q;
    end

    // Reset parks the raster on the last pixel of a frame so the first
    // pixel advance lands on (0, 0) and counts as frame 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            bright_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else if (tick) begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign bright      = bright_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
